ex_div_unit: RTL
================

Name: ex_div_unit

Overview:
- Iterative 64-bit integer divider in the EX stage; executes RV64M DIV/DIVU/REM/REMU taken from the ID/EX register output.
- It is the back-pressure end of the ID/EX interface. It drives the ID/EX `stall` input so the held instruction stays in place for the whole division.
- It then releases the instruction in the same cycle the result becomes valid.
- Restoring shift-subtract algorithm, one quotient bit per cycle.

Parameters:
- XLEN, 64, operand/result width; iteration count equals XLEN.
- CNT_W, 7, width of the iteration counter; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous kill of any in-flight operation (branch mispredict/exception).
- valid_i  input  1  ID/EX holds a divide instruction.
- op_i  input  2  00 DIVU, 01 DIV, 10 REMU, 11 REM.
- a_i  input  XLEN  dividend (rs1 value).
- b_i  input  XLEN  divisor (rs2 value).
- stall_o  output  1  to ID/EX `stall` and upstream stall logic.
- done_o  output  1  one-cycle pulse: result_o valid this cycle.
- result_o  output  XLEN  quotient or remainder.

Behaviour:
- Reset (reset==0, async): state=IDLE; counter, internal registers, result_o, done_o all 0. stall_o=0 (combinational from IDLE with valid_i gated off during reset).
- States:
  - IDLE: when valid_i==1 and flush==0, accept the operation. Latch op, abs(a), abs(b), and the sign flags (signed ops only).
    - If b_i==0 or signed overflow, go to DONE.
    - Otherwise go to BUSY with counter=XLEN.
  - BUSY: each cycle shift {rem,quot} left by 1 and trial-subtract the divisor. If non-negative, keep the difference and set quot[0]=1. Decrement the counter. When the counter reaches 1 on this edge, go to DONE.
  - DONE: result_o registered, done_o=1 for exactly this cycle, then go to IDLE unconditionally. valid_i is still high here and is NOT re-accepted.
- stall_o = (state==IDLE && valid_i) || state==BUSY; it is combinational and is 0 in DONE.
- Latency, normal case (issue cycle = cycle 0):
  - stall_o high in cycles 0..64 (65 cycles).
  - done_o high in cycle 65.
  - ID/EX advances at the end of cycle 65.
- Latency, special cases: stall_o high in cycle 0 only; done_o in cycle 1.
- Back-to-back divides: the next valid_i is seen in IDLE in cycle 66 and accepted; there is no bubble beyond the DONE cycle.
- Sign fix-up (signed ops):
  - Quotient is negated when sign(a)!=sign(b).
  - Remainder takes the sign of a.
  - Computed with XLEN-bit two's complement, wrapping.
- Special cases:
  - b==0: quotient = all ones; remainder = a_i (unmodified), for both signed and unsigned ops.
  - DIV/REM with a=-2^63 and b=-1: quotient = -2^63, remainder = 0.
- result_o holds its last value until the next DONE; it updates only on entry to DONE.
- flush: in any state, next state=IDLE and done_o=0; it overrides acceptance and DONE. Because stall_o is combinational, stall_o is 0 on the cycle after flush unless a new valid_i appears.
- Reset mid-operation aborts immediately to the reset values.
- Operand changes on a_i/b_i/op_i while BUSY are ignored; latched copies are used.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- When defined: in IDLE, if abs(a) < abs(b) (unsigned compare of the magnitudes), go straight to DONE. Quotient=0, remainder=a_i. Latency is the same as the special cases: stall_o in cycle 0 only, done_o in cycle 1.
- When undefined: these cases take the full 64 iterations and give identical results.

Test Plan:
- DIVU a=100, b=7 -> stall_o high 65 cycles; done_o in cycle 65, result_o=14. Repeat as REMU -> 2.
- DIV a=-100, b=7 -> result_o=-14 (0xFFFF_FFFF_FFFF_FFF2). REM -> -2. REM a=100, b=-7 -> 2.
- DIVU a=5, b=0 -> done_o in cycle 1, result_o=0xFFFF_FFFF_FFFF_FFFF. REM a=5, b=0 -> 5. DIV a=0x8000_0000_0000_0000, b=-1 -> 0x8000_0000_0000_0000, REM -> 0.
- Two back-to-back DIVU (40/4 then 9/3) with valid_i held high across DONE -> exactly two done_o pulses, results 10 then 3, no re-execution of the first.
- flush asserted in cycle 30 of a DIVU -> state IDLE, stall_o=0 next cycle, no done_o. reset pulled low in cycle 10 of another op -> outputs 0 immediately.
- With DIV_EARLY_OUT_EN: DIVU a=3, b=10 -> done_o in cycle 1, result_o=0. REMU -> 3. Without the macro, the same results arrive in cycle 65.

Source files
------------

// File: rtl/ex_div_unit.sv
// ex_div_unit: iterative 64-bit RV64M divider (DIV/DIVU/REM/REMU) in the EX stage.
// Restoring shift-subtract, one quotient bit per cycle. Holds the ID/EX
// register via stall_o while it is accepting or iterating, and releases it
// in the cycle done_o pulses.
// Optional build macro: DIV_EARLY_OUT_EN -- when |a| < |b| the result is
// produced without iterating (quotient 0, remainder a).
module ex_div_unit #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            valid_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [XLEN-1:0]  ONE     = XLEN'(1);
    localparam logic [XLEN-1:0]  INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ITR = CNT_W'(XLEN);

    // Two's-complement negate when requested (wraps, so -INT_MIN == INT_MIN).
    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + ONE) : v;
    endfunction

    // Sign fix-up of the unsigned magnitudes: quotient negated on sign
    // mismatch, remainder follows the dividend's sign.
    function automatic logic [XLEN-1:0] fixup(input logic [XLEN-1:0] q,
                                              input logic [XLEN-1:0] r,
                                              input logic            is_rem,
                                              input logic            neg_q,
                                              input logic            neg_r);
        return is_rem ? neg_if(r, neg_r) : neg_if(q, neg_q);
    endfunction

    logic [1:0]      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quot_q, quot_d;
    logic [XLEN-1:0] div_q, div_d;
    logic            is_rem_q, is_rem_d;
    logic            negq_q, negq_d;
    logic            nega_q, nega_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            signed_op, a_neg, b_neg, b_zero, ovf, early;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   rem_sh, trial;
    logic [XLEN-1:0] rem_nx, quot_nx;

    // Operand decode for the IDLE acceptance decision.
    always_comb begin
        signed_op = op_i[0];
        a_neg     = signed_op & a_i[XLEN-1];
        b_neg     = signed_op & b_i[XLEN-1];
        a_mag     = neg_if(a_i, a_neg);
        b_mag     = neg_if(b_i, b_neg);
        b_zero    = (b_i == '0);
        ovf       = signed_op && (a_i == INT_MIN) && (b_i == '1);
`ifdef DIV_EARLY_OUT_EN
        early     = (a_mag < b_mag);
`else
        early     = 1'b0;
`endif
    end

    // One restoring step: shift {rem,quot} left, keep the difference if it does not borrow.
    always_comb begin
        rem_sh = {rem_q, quot_q[XLEN-1]};
        trial  = rem_sh - {1'b0, div_q};
        if (!trial[XLEN]) begin
            rem_nx  = trial[XLEN-1:0];
            quot_nx = {quot_q[XLEN-2:0], 1'b1};
        end else begin
            rem_nx  = rem_sh[XLEN-1:0];
            quot_nx = {quot_q[XLEN-2:0], 1'b0};
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        div_d    = div_q;
        is_rem_d = is_rem_q;
        negq_d   = negq_q;
        nega_d   = nega_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (valid_i && !flush) begin
                    is_rem_d = op_i[1];
                    negq_d   = a_neg ^ b_neg;
                    nega_d   = a_neg;
                    div_d    = b_mag;
                    quot_d   = a_mag;
                    rem_d    = '0;
                    if (b_zero) begin
                        state_d  = S_DONE;
                        result_d = op_i[1] ? a_i : '1;
                    end else if (ovf) begin
                        state_d  = S_DONE;
                        result_d = op_i[1] ? '0 : a_i;
                    end else if (early) begin
                        state_d  = S_DONE;
                        result_d = op_i[1] ? a_i : '0;
                    end else begin
                        state_d  = S_BUSY;
                        cnt_d    = CNT_ITR;
                    end
                end
            end
            S_BUSY: begin
                rem_d  = rem_nx;
                quot_d = quot_nx;
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d  = S_DONE;
                    result_d = fixup(quot_nx, rem_nx, is_rem_q, negq_q, nega_q);
                end
            end
            S_DONE: begin
                // valid_i is still high here; the instruction is leaving, not new.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A kill wins over everything and must not publish a result.
        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    // State and datapath registers; async active-low reset clears everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            div_q    <= '0;
            is_rem_q <= 1'b0;
            negq_q   <= 1'b0;
            nega_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            div_q    <= div_d;
            is_rem_q <= is_rem_d;
            negq_q   <= negq_d;
            nega_q   <= nega_d;
            result_q <= result_d;
        end
    end

    assign stall_o  = reset && ((state_q == S_IDLE && valid_i) || state_q == S_BUSY);
    assign done_o   = (state_q == S_DONE) && !flush;
    assign result_o = result_q;

endmodule
